imm_pack: RTL and testbench

- Inverse of the execute-side immediate extender.
- Takes a 32-bit extended immediate plus an ImmSrc code and packs it into the 22-bit instruction immediate field.
- Checks that the value is exactly representable, so re-extending it returns the same 32-bit value.
- Sits in the instruction loader path: assembler stub or UART boot loader feeds it; the packed word goes to instruction-memory write logic.
- 2-stage valid/ready pipeline at full throughput.

---
 rtl/imm_pack_pkg.sv | 38 +++
 rtl/imm_pack_if.sv | 26 ++
 rtl/imm_pack_check.sv | 23 ++
 rtl/imm_pack.sv | 123 ++++++++++++
 tb/tb_imm_pack.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pack_pkg.sv
// Shared types and constants for the immediate packer (inverse of the execute-side extender).
package imm_pack_pkg;

  localparam int unsigned IMM_W   = 32;
  localparam int unsigned FIELD_W = 22;
  localparam int unsigned UIMM_W  = 10;
  localparam int unsigned CNT_W   = 16;
  // Highest extended-immediate bit a branch field can carry (word offset, sign bit)
  localparam int unsigned BR_HI   = FIELD_W + 1;

  typedef enum logic [1:0] {
    IMM_DP    = 2'b00,
    IMM_MEM   = 2'b01,
    IMM_BR    = 2'b10,
    IMM_UNDEF = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic [IMM_W-1:0]   imm;
    imm_src_e           src;
    logic [FIELD_W-1:0] base;
    logic               err;
  } stage_t;

  // True when re-extending the packed field would not reproduce imm exactly
  function automatic logic imm_range_err(input imm_src_e src, input logic [IMM_W-1:0] imm);
    logic err;
    err = 1'b1;
    case (src)
      IMM_DP, IMM_MEM: err = |imm[IMM_W-1:UIMM_W];
      IMM_BR:          err = (|imm[1:0]) ||
                             (imm[IMM_W-1:BR_HI+1] != {(IMM_W-BR_HI-1){imm[BR_HI]}});
      default:         err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/imm_pack_if.sv
// Request/result bus of the immediate packer.
interface imm_pack_if import imm_pack_pkg::*; ();

  logic               in_valid;
  logic               in_ready;
  logic [IMM_W-1:0]   in_imm;
  imm_src_e           in_src;
  logic [FIELD_W-1:0] in_base;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_field;
  logic               out_err;
  logic               err_sticky;
  logic [CNT_W-1:0]   err_count;

  modport master (
    output in_valid, in_imm, in_src, in_base, out_ready,
    input  in_ready, out_valid, out_field, out_err, err_sticky, err_count
  );

  modport slave (
    input  in_valid, in_imm, in_src, in_base, out_ready,
    output in_ready, out_valid, out_field, out_err, err_sticky, err_count
  );

endinterface

// File: rtl/imm_pack_check.sv
// Combinational pack + representability check: (src, imm, base) -> (field, err).
module imm_pack_check
  import imm_pack_pkg::*;
(
  input  imm_src_e           src_i,
  input  logic [IMM_W-1:0]   imm_i,
  input  logic [FIELD_W-1:0] base_i,
  output logic [FIELD_W-1:0] field_c_o,
  output logic               err_c_o
);

  // Select which immediate bits land in the field; undefined source passes base through
  always_comb begin
    field_c_o = base_i;
    case (src_i)
      IMM_DP, IMM_MEM: field_c_o = {base_i[FIELD_W-1:UIMM_W], imm_i[UIMM_W-1:0]};
      IMM_BR:          field_c_o = imm_i[BR_HI:2];
      default:         field_c_o = base_i;
    endcase
    err_c_o = imm_range_err(src_i, imm_i);
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer.
// Optional error counter enabled by defining IMM_PACK_ERRCNT_EN.
module imm_pack
  import imm_pack_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  imm_pack_if.slave bus
);

  logic               s1_valid_q, s1_valid_d;
  stage_t             s1_q, s1_d;
  logic               out_valid_q, out_valid_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;
  logic               s2_adv_c, s1_adv_c, in_hs_c, out_hs_c;
  logic [FIELD_W-1:0] chk_field_c;
  logic               chk_err_c;

  // Stall chain: a stage advances when its downstream slot is empty or draining
  always_comb begin
    s2_adv_c = !out_valid_q || bus.out_ready;
    s1_adv_c = !s1_valid_q || s2_adv_c;
    in_hs_c  = bus.in_valid && s1_adv_c;
    out_hs_c = out_valid_q && bus.out_ready;
  end

  assign bus.in_ready   = s1_adv_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_field  = field_q;
  assign bus.out_err    = err_q;
  assign bus.err_sticky = sticky_q;

  imm_pack_check u_check (
    .src_i     (s1_q.src),
    .imm_i     (s1_q.imm),
    .base_i    (s1_q.base),
    .field_c_o (chk_field_c),
    .err_c_o   (chk_err_c)
  );

  // Next-state for both pipeline stages and the sticky error flag
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    field_d     = field_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    if (s1_adv_c) begin
      s1_valid_d = bus.in_valid;
    end
    if (in_hs_c) begin
      s1_d.imm  = bus.in_imm;
      s1_d.src  = bus.in_src;
      s1_d.base = bus.in_base;
      s1_d.err  = imm_range_err(bus.in_src, bus.in_imm);
    end
    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
    end
    if (s1_valid_q && s2_adv_c) begin
      field_d = chk_field_c;
      err_d   = s1_q.err;
    end
    if (out_hs_c && err_q) begin
      sticky_d = 1'b1;
    end
  end

  // Pipeline and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      field_q     <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      field_q     <= field_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
    end
  end

  // The flag captured from the raw inputs must agree with the packer's own check
  always_ff @(posedge clk) begin
    if (rst_n && s1_valid_q) begin
      a_err_consistent: assert (chk_err_c == s1_q.err);
    end
  end

`ifdef IMM_PACK_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of erroneous result handshakes
  always_comb begin
    cnt_d = cnt_q;
    if (out_hs_c && err_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.err_count = cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: single-shot packing, stalls, mid-stream reset, counter.
module tb_imm_pack;
  import imm_pack_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_pack_if bus ();

  imm_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Present one request and hold it until accepted (bounded); returns at edge+1
  task automatic issue(input imm_src_e src, input logic [31:0] imm, input logic [21:0] base);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_src   = src;
    bus.in_imm   = imm;
    bus.in_base  = base;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout: in_ready never seen high within 20 cycles");
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_src    = IMM_DP;
    bus.in_imm    = '0;
    bus.in_base   = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++;
    if (bus.out_field !== 22'h0) begin errors++; $display("FAIL reset_out_field: got %h want 000000", bus.out_field); end
    checks++;
    if (bus.out_err !== 1'b0 || bus.err_sticky !== 1'b0) begin
      errors++; $display("FAIL reset_err_flags: got err=%0b sticky=%0b want 0 0", bus.out_err, bus.err_sticky);
    end
    checks++;
    if (bus.err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count: got %h want 0000", bus.err_count); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dp();
    bus.out_ready = 1'b1;
    issue(IMM_DP, 32'h0000_03FF, 22'h2AB400);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dp_early_valid: got %0b want 0 after one cycle", bus.out_valid); end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_field !== 22'h2AB7FF || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL dp_result: got v=%0b field=%h err=%0b want v=1 field=2ab7ff err=0",
               bus.out_valid, bus.out_field, bus.out_err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b0) begin
      errors++; $display("FAIL dp_drain: got v=%0b sticky=%0b want 0 0", bus.out_valid, bus.err_sticky);
    end
  endtask

  task automatic test_mem_err();
    logic [15:0] exp_cnt;
`ifdef IMM_PACK_ERRCNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    issue(IMM_MEM, 32'h0000_0400, 22'h2AB400);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_field !== 22'h2AB400 || bus.out_err !== 1'b1) begin
      errors++;
      $display("FAIL mem_result: got v=%0b field=%h err=%0b want v=1 field=2ab400 err=1",
               bus.out_valid, bus.out_field, bus.out_err);
    end
    checks++;
    if (bus.err_sticky !== 1'b0) begin errors++; $display("FAIL mem_sticky_early: got %0b want 0 before handshake", bus.err_sticky); end
    @(posedge clk); #1;
    checks++;
    if (bus.err_sticky !== 1'b1) begin errors++; $display("FAIL mem_sticky: got %0b want 1", bus.err_sticky); end
    checks++;
    if (bus.err_count !== exp_cnt) begin errors++; $display("FAIL mem_err_count: got %h want %h", bus.err_count, exp_cnt); end
  endtask

  task automatic test_branch();
    imm_src_e    srcs [4];
    logic [31:0] imms [4];
    logic [21:0] exp_f[4];
    logic        exp_e[4];
    srcs  = '{IMM_BR, IMM_BR, IMM_BR, IMM_BR};
    imms  = '{32'hFFFF_FFFC, 32'h0080_0000, 32'h0000_0006, 32'h007F_FFFC};
    exp_f = '{22'h3FFFFF, 22'h200000, 22'h000001, 22'h1FFFFF};
    exp_e = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(srcs[i], imms[i], 22'h123456);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_field !== exp_f[i] || bus.out_err !== exp_e[i]) begin
        errors++;
        $display("FAIL br_%0d: imm=%h got v=%0b field=%h err=%0b want v=1 field=%h err=%0b",
                 i, imms[i], bus.out_valid, bus.out_field, bus.out_err, exp_f[i], exp_e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_undef();
    issue(IMM_UNDEF, 32'h0000_0000, 22'h155555);
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_field !== 22'h155555 || bus.out_err !== 1'b1) begin
      errors++;
      $display("FAIL undef_result: got v=%0b field=%h err=%0b want v=1 field=155555 err=1",
               bus.out_valid, bus.out_field, bus.out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    imm_src_e    srcs [8];
    logic [31:0] imms [8];
    logic [21:0] bases[8];
    logic [21:0] exp_f[8];
    logic        exp_e[8];
    bit          pat  [4];
    int          sent, got, occ;
    bit          prev_stall, in_hs, out_hs, exp_rdy;
    logic [21:0] prev_field;
    logic        prev_err;
    srcs  = '{IMM_DP, IMM_MEM, IMM_BR, IMM_BR, IMM_UNDEF, IMM_DP, IMM_MEM, IMM_BR};
    imms  = '{32'h0000_0001, 32'h0000_03FF, 32'h0000_0004, 32'hFFFF_FFF8,
              32'h0000_0000, 32'h0000_0800, 32'h0000_0155, 32'h007F_FFFC};
    bases = '{22'h000000, 22'h3FFC00, 22'h000000, 22'h000000,
              22'h0ABCDE, 22'h155400, 22'h2AA800, 22'h000000};
    exp_f = '{22'h000001, 22'h3FFFFF, 22'h000001, 22'h3FFFFE,
              22'h0ABCDE, 22'h155400, 22'h2AA955, 22'h1FFFFF};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; got = 0; occ = 0;
    prev_stall = 1'b0; prev_field = '0; prev_err = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      bus.out_ready = pat[cyc % 4];
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.in_src  = srcs[sent];
        bus.in_imm  = imms[sent];
        bus.in_base = bases[sent];
      end
      #1;
      exp_rdy = !(occ == 2 && !pat[cyc % 4]);
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_in_ready cyc %0d: got %0b want %0b", cyc, bus.in_ready, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_field !== prev_field || bus.out_err !== prev_err) begin
          errors++;
          $display("FAIL b2b_hold cyc %0d: got v=%0b field=%h err=%0b want v=1 field=%h err=%0b",
                   cyc, bus.out_valid, bus.out_field, bus.out_err, prev_field, prev_err);
        end
      end
      in_hs  = bus.in_valid && bus.in_ready;
      out_hs = bus.out_valid && bus.out_ready;
      if (out_hs) begin
        checks++;
        if (got >= 8 || bus.out_field !== exp_f[got] || bus.out_err !== exp_e[got]) begin
          errors++;
          $display("FAIL b2b_out_%0d: got field=%h err=%0b want field=%h err=%0b",
                   got, bus.out_field, bus.out_err, exp_f[got % 8], exp_e[got % 8]);
        end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_field = bus.out_field;
      prev_err   = bus.out_err;
      occ  = occ + int'(in_hs) - int'(out_hs);
      sent = sent + int'(in_hs);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d results want 8", got); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra: got out_valid %0b want 0 after drain", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.out_ready = 1'b0;
    issue(IMM_UNDEF, 32'h0000_0000, 22'h155555);
    issue(IMM_DP,    32'h0000_0001, 22'h000000);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_full: got v=%0b rdy=%0b want v=1 rdy=0", bus.out_valid, bus.in_ready);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b0 || bus.out_err !== 1'b0 || bus.out_field !== 22'h0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%0b sticky=%0b err=%0b field=%h want 0 0 0 000000",
               bus.out_valid, bus.err_sticky, bus.out_err, bus.out_field);
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.err_count !== 16'h0) begin
      errors++; $display("FAIL rstmid_ready_cnt: got rdy=%0b cnt=%h want 1 0000", bus.in_ready, bus.err_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rstmid_ghost: got out_valid=1 after reset with no input want 0"); end
  endtask

`ifdef IMM_PACK_ERRCNT_EN
  task automatic err_burst(input int n);
    bus.in_src   = IMM_UNDEF;
    bus.in_imm   = '0;
    bus.in_base  = '0;
    bus.in_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_errcnt_sat();
    bus.out_ready = 1'b1;
    err_burst(65534);
    checks++;
    if (bus.err_count !== 16'hFFFE) begin errors++; $display("FAIL cnt_pre_sat: got %h want fffe", bus.err_count); end
    err_burst(5);
    checks++;
    if (bus.err_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h want ffff", bus.err_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_dp();
    test_mem_err();
    test_branch();
    test_undef();
    test_back_to_back();
    test_reset_mid();
`ifdef IMM_PACK_ERRCNT_EN
    test_errcnt_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
